// File: rtl/prbs5_ber_checker_if.sv
// Symbol input / BER readout bundle for prbs5_ber_checker.
// o_inverted is present only when PRBS5_CHK_POL_AUTO_EN is defined.
interface prbs5_ber_checker_if #(
  parameter int NB_INPUT = 9,
  parameter int NB_CNT   = 32
);
  logic                       i_en;
  logic                       i_valid;
  logic signed [NB_INPUT-1:0] i_data;
  logic                       i_clear;
  logic                       o_bit;
  logic                       o_bit_valid;
  logic [1:0]                 o_state;
  logic                       o_locked;
  logic [NB_CNT-1:0]          o_bit_cnt;
  logic [NB_CNT-1:0]          o_err_cnt;
  logic [7:0]                 o_lock_loss_cnt;
`ifdef PRBS5_CHK_POL_AUTO_EN
  logic                       o_inverted;

  modport slave (
    input  i_en, i_valid, i_data, i_clear,
    output o_bit, o_bit_valid, o_state, o_locked,
    output o_bit_cnt, o_err_cnt, o_lock_loss_cnt, o_inverted
  );

  modport master (
    output i_en, i_valid, i_data, i_clear,
    input  o_bit, o_bit_valid, o_state, o_locked,
    input  o_bit_cnt, o_err_cnt, o_lock_loss_cnt, o_inverted
  );
`else
  modport slave (
    input  i_en, i_valid, i_data, i_clear,
    output o_bit, o_bit_valid, o_state, o_locked,
    output o_bit_cnt, o_err_cnt, o_lock_loss_cnt
  );

  modport master (
    output i_en, i_valid, i_data, i_clear,
    input  o_bit, o_bit_valid, o_state, o_locked,
    input  o_bit_cnt, o_err_cnt, o_lock_loss_cnt
  );
`endif
endinterface

// File: rtl/prbs5_ber_checker.sv
// Self-synchronising PRBS5 (r[n] = r[n-3] ^ r[n-5]) BER checker on sliced recovered symbols.
// Optional feature macro: PRBS5_CHK_POL_AUTO_EN (lock onto an inverted-polarity stream).
module prbs5_ber_checker #(
  parameter int NB_INPUT       = 9,
  parameter int NBF_INPUT      = 7,
  parameter int NB_CNT         = 32,
  parameter int SYNC_THRESHOLD = 16,
  parameter int LOSS_THRESHOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  prbs5_ber_checker_if.slave  bus
);

  localparam int MW = $clog2(SYNC_THRESHOLD + 1);
  localparam int EW = $clog2(LOSS_THRESHOLD + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [NB_CNT-1:0] sat_inc_cnt(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + {{(NB_CNT-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  state_e            state_q, state_d;
  logic              bit_q, bit_d;
  logic              bit_valid_q, bit_valid_d;
  logic              locked_q, locked_d;
  logic [4:0]        sr_q, sr_d;
  logic [2:0]        fill_q, fill_d;
  logic [MW-1:0]     match_q, match_d;
  logic [4:0]        win_cnt_q, win_cnt_d;
  logic [EW-1:0]     win_err_q, win_err_d;
  logic [NB_CNT-1:0] bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]        loss_q, loss_d;

  logic              pred_s;
  logic              cmp_bit_s;
  logic              err_s;
  logic [4:0]        shift_rx_s;
  logic [2:0]        fill_inc_s;
  logic [MW-1:0]     match_inc_s;
  logic [EW-1:0]     win_err_sum_s;
  logic              unused_s;

`ifdef PRBS5_CHK_POL_AUTO_EN
  logic              inv_q, inv_d;
  logic [MW-1:0]     inv_cnt_q, inv_cnt_d;
  logic [MW-1:0]     inv_inc_s;

  assign inv_inc_s = inv_cnt_q + {{(MW-1){1'b0}}, 1'b1};
  assign cmp_bit_s = bit_q ^ inv_q;
`else
  assign cmp_bit_s = bit_q;
`endif

  // A hard slicer only looks at the sign; the magnitude bits are deliberately dropped.
  assign unused_s = ^{bus.i_data[NB_INPUT-2:0], NBF_INPUT[0]};

  assign pred_s        = sr_q[2] ^ sr_q[4];
  assign shift_rx_s    = {sr_q[3:0], bit_q};
  assign fill_inc_s    = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
  assign match_inc_s   = match_q + {{(MW-1){1'b0}}, 1'b1};
  assign err_s         = cmp_bit_s ^ pred_s;
  assign win_err_sum_s = win_err_q + {{(EW-1){1'b0}}, err_s};

  // Slicer stage: sign bit to data bit, qualified by enable.
  always_comb begin
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    if (bus.i_en && bus.i_valid) begin
      bit_d       = ~bus.i_data[NB_INPUT-1];
      bit_valid_d = 1'b1;
    end else begin
      bit_valid_d = 1'b0;
    end
  end

  // Sync FSM, reference register and BER counters.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    loss_d    = loss_q;
`ifdef PRBS5_CHK_POL_AUTO_EN
    inv_d     = inv_q;
    inv_cnt_d = inv_cnt_q;
`endif
    if (!bus.i_en) begin
      state_d   = ST_HUNT;
      fill_d    = 3'd0;
      match_d   = '0;
      win_cnt_d = 5'd0;
      win_err_d = '0;
`ifdef PRBS5_CHK_POL_AUTO_EN
      inv_d     = 1'b0;
      inv_cnt_d = '0;
`endif
    end else if (bit_valid_q) begin
      case (state_q)
        ST_HUNT: begin
          sr_d    = shift_rx_s;
          fill_d  = fill_inc_s;
          match_d = '0;
`ifdef PRBS5_CHK_POL_AUTO_EN
          inv_cnt_d = '0;
`endif
          if ((fill_inc_s == 3'd5) && (shift_rx_s != 5'd0)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_CHECK: begin
          sr_d = shift_rx_s;
          if (!err_s) begin
            match_d = match_inc_s;
`ifdef PRBS5_CHK_POL_AUTO_EN
            inv_cnt_d = '0;
`endif
            if (match_inc_s == MW'(SYNC_THRESHOLD)) begin
              state_d = ST_LOCKED;
              match_d = '0;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            match_d = '0;
`ifdef PRBS5_CHK_POL_AUTO_EN
            inv_cnt_d = inv_inc_s;
            // Complementing the history leaves the free-running reference in true polarity.
            if (inv_inc_s == MW'(SYNC_THRESHOLD)) begin
              state_d   = ST_LOCKED;
              inv_d     = 1'b1;
              inv_cnt_d = '0;
              sr_d      = ~shift_rx_s;
            end else begin
              state_d = ST_CHECK;
            end
`endif
          end
        end
        ST_LOCKED: begin
          sr_d      = {sr_q[3:0], pred_s};
          bit_cnt_d = sat_inc_cnt(bit_cnt_q);
          if (err_s) begin
            err_cnt_d = sat_inc_cnt(err_cnt_q);
          end else begin
            err_cnt_d = err_cnt_q;
          end
          if (win_err_sum_s == EW'(LOSS_THRESHOLD)) begin
            state_d   = ST_HUNT;
            loss_d    = sat_inc_8(loss_q);
            fill_d    = 3'd0;
            match_d   = '0;
            win_cnt_d = 5'd0;
            win_err_d = '0;
`ifdef PRBS5_CHK_POL_AUTO_EN
            inv_d     = 1'b0;
`endif
          end else if (win_cnt_q == 5'd31) begin
            win_cnt_d = 5'd0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 5'd1;
            win_err_d = win_err_sum_s;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (bus.i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
      loss_d    = 8'd0;
    end else begin
      loss_d = loss_d;
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sr_q        <= 5'd0;
      fill_q      <= 3'd0;
      match_q     <= '0;
      win_cnt_q   <= 5'd0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      loss_q      <= 8'd0;
`ifdef PRBS5_CHK_POL_AUTO_EN
      inv_q       <= 1'b0;
      inv_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      locked_q    <= locked_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      loss_q      <= loss_d;
`ifdef PRBS5_CHK_POL_AUTO_EN
      inv_q       <= inv_d;
      inv_cnt_q   <= inv_cnt_d;
`endif
    end
  end

  assign bus.o_bit           = bit_q;
  assign bus.o_bit_valid     = bit_valid_q;
  assign bus.o_state         = state_q;
  assign bus.o_locked        = locked_q;
  assign bus.o_bit_cnt       = bit_cnt_q;
  assign bus.o_err_cnt       = err_cnt_q;
  assign bus.o_lock_loss_cnt = loss_q;
`ifdef PRBS5_CHK_POL_AUTO_EN
  assign bus.o_inverted      = inv_q;
`endif

endmodule

// File: tb/tb_prbs5_ber_checker.sv
// Randomised bench for prbs5_ber_checker against a sequence-level model of the sync/BER rules.
module tb_prbs5_ber_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prbs5_ber_checker_if #(.NB_INPUT(9), .NB_CNT(32)) bus ();

  prbs5_ber_checker #(
    .NB_INPUT(9), .NBF_INPUT(7), .NB_CNT(32),
    .SYNC_THRESHOLD(16), .LOSS_THRESHOLD(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;
  bit watch_lock = 1'b0;
  bit saw_locked = 1'b0;

  // Stimulus PRBS5 table, one period.
  bit prbs_seq [31];
  int pidx = 0;

  // Model: history of last five bits (index 0 oldest), plus plain counters.
  bit     m_q [$];
  int     m_state, m_fill, m_run, m_irun, m_winpos, m_winerr, m_loss;
  longint m_bits, m_errs;
  bit     m_b, m_bv, m_inv;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit next_prbs();
    bit b;
    b = prbs_seq[pidx];
    pidx = (pidx + 1) % 31;
    return b;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 5; i++) m_q.push_back(1'b0);
    m_state = 0; m_fill = 0; m_run = 0; m_irun = 0;
    m_winpos = 0; m_winerr = 0; m_loss = 0;
    m_bits = 0; m_errs = 0; m_b = 1'b0; m_bv = 1'b0; m_inv = 1'b0;
  endtask

  task automatic push_hist(input bit b);
    m_q.push_back(b);
    void'(m_q.pop_front());
  endtask

  task automatic model_process(input bit b);
    bit p, e, any;
    p = m_q[0] ^ m_q[2];
    case (m_state)
      0: begin
        push_hist(b);
        if (m_fill < 5) m_fill++;
        any = 1'b0;
        foreach (m_q[i]) any |= m_q[i];
        if (m_fill == 5 && any) begin
          m_state = 1; m_run = 0; m_irun = 0;
        end
      end
      1: begin
        if (b == p) begin m_run++; m_irun = 0; end
        else begin m_run = 0; m_irun++; end
        push_hist(b);
        if (m_run == 16) begin
          m_state = 2; m_winpos = 0; m_winerr = 0;
        end
`ifdef PRBS5_CHK_POL_AUTO_EN
        else if (m_irun == 16) begin
          m_state = 2; m_inv = 1'b1; m_winpos = 0; m_winerr = 0;
          foreach (m_q[i]) m_q[i] = ~m_q[i];
        end
`endif
      end
      2: begin
        e = ((b ^ m_inv) != p);
        push_hist(p);
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (e && m_errs < 64'hFFFF_FFFF) m_errs++;
        m_winerr += int'(e);
        if (m_winerr == 8) begin
          m_state = 0; m_fill = 0; m_inv = 1'b0;
          if (m_loss < 255) m_loss++;
        end else begin
          m_winpos++;
          if (m_winpos == 32) begin m_winpos = 0; m_winerr = 0; end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // Model advances on each active edge from the inputs the DUT also samples.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (!bus.i_en) begin
          m_state = 0; m_fill = 0; m_run = 0; m_irun = 0;
          m_winpos = 0; m_winerr = 0; m_inv = 1'b0;
        end else if (m_bv) begin
          model_process(m_b);
        end
        if (bus.i_clear) begin m_bits = 0; m_errs = 0; m_loss = 0; end
        if (bus.i_en && bus.i_valid) begin m_b = ~bus.i_data[8]; m_bv = 1'b1; end
        else m_bv = 1'b0;
      end
    end
  end

  // Cycle compare on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("o_bit_valid", bus.o_bit_valid, m_bv);
        if (m_bv) check("o_bit", bus.o_bit, m_b);
        check("o_state", bus.o_state, m_state);
        check("o_locked", bus.o_locked, m_state == 2);
        check("o_bit_cnt", bus.o_bit_cnt, m_bits);
        check("o_err_cnt", bus.o_err_cnt, m_errs);
        check("o_lock_loss_cnt", bus.o_lock_loss_cnt, m_loss);
`ifdef PRBS5_CHK_POL_AUTO_EN
        check("o_inverted", bus.o_inverted, m_inv);
`endif
        if (watch_lock && bus.o_state == 2'd2) saw_locked = 1'b1;
      end
    end
  end

  task automatic send_sym(input bit b, input int gap);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = {~b, 8'($urandom)};
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    int div [6];
    bit b;
    prbs_seq[0] = 1'b1;
    for (int n = 1; n < 5; n++) prbs_seq[n] = 1'b0;
    for (int n = 5; n < 31; n++) prbs_seq[n] = prbs_seq[n-3] ^ prbs_seq[n-5];

    rst_n = 1'b0;
    bus.i_en = 1'b1; bus.i_valid = 1'b0; bus.i_clear = 1'b0; bus.i_data = 9'sd0;
    @(posedge clk);
    cmp_on = 1'b1;
    // Reset held with symbol strobes: nothing may count.
    repeat (3) begin
      @(negedge clk);
      bus.i_valid = ~bus.i_valid;
      bus.i_data  = 9'sd127;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", bus.o_state, 0);
    check("rst_bit_cnt", bus.o_bit_cnt, 0);
    check("rst_bit_valid", bus.o_bit_valid, 0);

    // Clean stream, one symbol every 32 clocks.
    for (int i = 0; i < 100; i++) begin
      send_sym(next_prbs(), 32);
      if (i == 19) check("locked_after_20", bus.o_locked, 0);
      if (i == 20) check("locked_after_21", bus.o_locked, 1);
    end
    check("clean_err_cnt", bus.o_err_cnt, 0);
    check("clean_bit_cnt", bus.o_bit_cnt, 79);
    check("model_clean_bits", m_bits, 79);

    // Sparse single-bit errors.
    for (int i = 0; i < 400; i++) begin
      b = next_prbs();
      if (i % 40 == 39) b = ~b;
      send_sym(b, $urandom_range(2, 5));
    end
    check("sparse_err_cnt", bus.o_err_cnt, 10);
    check("sparse_locked", bus.o_locked, 1);
    check("sparse_loss", bus.o_lock_loss_cnt, 0);
    check("sparse_bit_cnt", bus.o_bit_cnt, 479);

    // One pad bit aligns the burst to a fresh 32-bit window.
    send_sym(next_prbs(), 3);
    for (int i = 0; i < 8; i++) send_sym(~next_prbs(), 3);
    check("burst_state", bus.o_state, 0);
    check("burst_loss", bus.o_lock_loss_cnt, 1);
    check("burst_err_cnt", bus.o_err_cnt, 18);
    for (int i = 0; i < 21; i++) begin
      send_sym(next_prbs(), 3);
      if (i == 19) check("relock_after_20", bus.o_locked, 0);
      if (i == 20) check("relock_after_21", bus.o_locked, 1);
    end
    for (int i = 0; i < 10; i++) send_sym(next_prbs(), 2);

    // Clear on the same edge that would count a bit.
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_data = {~next_prbs(), 8'($urandom)};
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    check("clear_bit_cnt", bus.o_bit_cnt, 0);
    check("clear_err_cnt", bus.o_err_cnt, 0);
    check("clear_loss", bus.o_lock_loss_cnt, 0);
    check("clear_locked", bus.o_locked, 1);

    // Disabled: strobes ignored, back to HUNT without a lock loss.
    bus.i_en = 1'b0;
    for (int i = 0; i < 5; i++) send_sym(next_prbs(), 3);
    check("dis_state", bus.o_state, 0);
    check("dis_loss", bus.o_lock_loss_cnt, 0);
    bus.i_en = 1'b1;

    // Random error densities and sporadic clears.
    div = '{0, 16, 3, 0, 8, 2};
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 50; i++) begin
        b = next_prbs();
        if (div[blk] != 0 && $urandom_range(0, div[blk] - 1) == 0) b = ~b;
        bus.i_clear = ($urandom_range(0, 63) == 0);
        send_sym(b, $urandom_range(2, 6));
        bus.i_clear = 1'b0;
      end
    end

    // Reset mid-operation.
    @(negedge clk);
    rst_n = 1'b0; bus.i_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bus.i_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_state", bus.o_state, 0);
    check("mid_rst_bit_cnt", bus.o_bit_cnt, 0);
    check("mid_rst_loss", bus.o_lock_loss_cnt, 0);

    // Inverted-polarity stream.
    saw_locked = 1'b0;
    watch_lock = 1'b1;
    for (int i = 0; i < 100; i++) send_sym(~next_prbs(), 3);
    watch_lock = 1'b0;
`ifdef PRBS5_CHK_POL_AUTO_EN
    check("inv_locked", bus.o_locked, 1);
    check("inv_inverted", bus.o_inverted, 1);
    check("inv_err_cnt", bus.o_err_cnt, 0);
`else
    check("inv_never_locked", saw_locked, 0);
    check("inv_state", bus.o_state, 1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
